// File: rtl/uart_pkg.sv
// Shared UART register map, status bit positions and boot-loader state encoding.
package uart_pkg;

  localparam logic [3:0] UART_REG_RX   = 4'h0;
  localparam logic [3:0] UART_REG_TX   = 4'h4;
  localparam logic [3:0] UART_REG_CONF = 4'h8;

  localparam int unsigned RX_EMPTY_BIT = 31;
  localparam int unsigned RX_ERR_BIT   = 9;
  localparam int unsigned TX_FULL_BIT  = 31;

  typedef logic [3:0] loader_state_t;

  localparam loader_state_t StIdle    = 4'd0;
  localparam loader_state_t StHunt    = 4'd1;
  localparam loader_state_t StAddr    = 4'd2;
  localparam loader_state_t StLen     = 4'd3;
  localparam loader_state_t StData    = 4'd4;
  localparam loader_state_t StSum     = 4'd5;
  localparam loader_state_t StErr     = 4'd6;
  localparam loader_state_t StReply   = 4'd7;
  localparam loader_state_t StReplyWr = 4'd8;
  localparam loader_state_t StDone    = 4'd9;

endpackage

// File: rtl/apb_master_seq.sv
// Single-transfer APB master: one request in, setup and access phases out, ack pulse back.
module apb_master_seq (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        req_i,
  input  logic        write_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [3:0]  paddr_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i
);

  logic        psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d, ack_q, ack_d;
  logic [3:0]  paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d, rdata_q, rdata_d;

  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    // Requests are only taken with PSEL low, so the bus always idles between transfers.
    if (!psel_q) begin
      if (req_i) begin
        psel_d   = 1'b1;
        pwrite_d = write_i;
        paddr_d  = addr_i;
        pwdata_d = wdata_i;
      end
    end else if (!penable_q) begin
      penable_d = 1'b1;
    end else if (pready_i) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
      rdata_d   = prdata_i;
      ack_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
    end
  end

  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign rdata_o   = rdata_q;
  assign ack_o     = ack_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Serial firmware loader: pulls framed bytes from the UART receiver over APB, writes the
// payload to memory and answers ACK/NAK through the transmitter register.
module uart_boot_loader
  import uart_pkg::*;
#(
  parameter logic [7:0]  MAGIC    = 8'hEB,
  parameter logic [31:0] MAX_LEN  = 32'h0010_0000,
  parameter logic [7:0]  ACK_BYTE = 8'h4B,
  parameter logic [7:0]  NAK_BYTE = 8'h45
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [3:0]  apb_PADDR,
  output logic        apb_PSEL,
  output logic        apb_PENABLE,
  output logic        apb_PWRITE,
  output logic [31:0] apb_PWDATA,
  input  logic [31:0] apb_PRDATA,
  input  logic        apb_PREADY,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] boot_addr,
  output logic        error
);

  loader_state_t state_q, state_d;
  logic          wait_q, wait_d, flush_q, flush_d, ok_q, ok_d;
  logic          done_q, done_d, error_q, error_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic [3:0]    strb_q, strb_d;
  logic [31:0]   addr_q, addr_d, len_q, len_d, ptr_q, ptr_d;
  logic [31:0]   buf_q, buf_d, waddr_q, waddr_d, boot_q, boot_d;

  logic          req, req_write, xfer_ack, fetching, byte_ok;
  logic [3:0]    req_addr;
  logic [31:0]   req_wdata, xfer_rdata, len_full;
  logic [7:0]    rx_byte;
  logic [1:0]    lane;
  logic          unused_rdata;

  apb_master_seq u_apb (
    .clk_i     (clk),
    .reset_ni  (reset_n),
    .req_i     (req),
    .write_i   (req_write),
    .addr_i    (req_addr),
    .wdata_i   (req_wdata),
    .ack_o     (xfer_ack),
    .rdata_o   (xfer_rdata),
    .psel_o    (apb_PSEL),
    .penable_o (apb_PENABLE),
    .pwrite_o  (apb_PWRITE),
    .paddr_o   (apb_PADDR),
    .pwdata_o  (apb_PWDATA),
    .prdata_i  (apb_PRDATA),
    .pready_i  (apb_PREADY)
  );

  assign unused_rdata = ^{xfer_rdata[30:10], xfer_rdata[8]};

  always_comb begin
    state_d = state_q;  wait_d = wait_q;  flush_d = flush_q;  ok_d = ok_q;
    cnt_d = cnt_q;  sum_d = sum_q;  strb_d = strb_q;  addr_d = addr_q;
    len_d = len_q;  ptr_d = ptr_q;  buf_d = buf_q;  waddr_d = waddr_q;  boot_d = boot_q;
    done_d = 1'b0;  error_d = 1'b0;
    req = 1'b0;  req_write = 1'b0;  req_addr = UART_REG_RX;  req_wdata = '0;

    rx_byte  = xfer_rdata[7:0];
    len_full = {rx_byte, len_q[31:8]};
    lane     = ptr_q[1:0];
    fetching = state_q inside {StHunt, StAddr, StLen, StData, StSum};
    byte_ok  = fetching && xfer_ack && !xfer_rdata[RX_EMPTY_BIT] && !xfer_rdata[RX_ERR_BIT];

    if (flush_q && mem_ready) begin
      flush_d = 1'b0;
      buf_d   = '0;
      strb_d  = '0;
    end

    if (xfer_ack) begin
      wait_d = 1'b0;
    end else if (!wait_q) begin
      // A pending memory flush holds off the next receiver read.
      if (fetching && !flush_q) req = 1'b1;
      if (state_q == StErr) begin
        req       = 1'b1;
        req_write = 1'b1;
      end
      if (state_q == StReply) begin
        req      = 1'b1;
        req_addr = UART_REG_TX;
      end
      if (state_q == StReplyWr) begin
        req       = 1'b1;
        req_write = 1'b1;
        req_addr  = UART_REG_TX;
        req_wdata = {24'h0, ok_q ? ACK_BYTE : NAK_BYTE};
      end
      wait_d = req;
    end

    if (fetching && xfer_ack && !xfer_rdata[RX_EMPTY_BIT] && xfer_rdata[RX_ERR_BIT]) begin
      state_d = StErr;
    end

    case (state_q)
      StIdle: if (enable) state_d = StHunt;
      StHunt: if (byte_ok && rx_byte == MAGIC) begin
        state_d = StAddr;
        cnt_d   = '0;
        sum_d   = '0;
      end
      StAddr: if (byte_ok) begin
        addr_d = {rx_byte, addr_q[31:8]};
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = StLen;
      end
      StLen: if (byte_ok) begin
        len_d = len_full;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          ptr_d = addr_q;
          if (len_full > MAX_LEN) state_d = StErr;
          else if (len_full == '0) state_d = StSum;
          else state_d = StData;
        end
      end
      StData: if (byte_ok) begin
        sum_d                     = sum_q + rx_byte;
        buf_d[{lane, 3'b000} +: 8] = rx_byte;
        strb_d[lane]              = 1'b1;
        len_d                     = len_q - 32'd1;
        ptr_d                     = ptr_q + 32'd1;
        if (lane == 2'd3 || len_q == 32'd1) begin
          flush_d = 1'b1;
          waddr_d = {ptr_q[31:2], 2'b00};
        end
        if (len_q == 32'd1) state_d = StSum;
      end
      StSum: if (byte_ok) begin
        ok_d    = (rx_byte == sum_q);
        state_d = (rx_byte == sum_q) ? StReply : StErr;
      end
      StErr: if (xfer_ack) begin
        ok_d    = 1'b0;
        state_d = StReply;
      end
      StReply: if (xfer_ack && !xfer_rdata[TX_FULL_BIT]) state_d = StReplyWr;
      StReplyWr: if (xfer_ack) begin
        if (ok_q) begin
          state_d = StDone;
          done_d  = 1'b1;
          boot_d  = addr_q;
        end else begin
          state_d = StHunt;
          error_d = 1'b1;
          sum_d   = '0;
          cnt_d   = '0;
          len_d   = '0;
          ptr_d   = '0;
          buf_d   = '0;
          strb_d  = '0;
        end
      end
      StDone: if (!enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;  wait_q <= 1'b0;  flush_q <= 1'b0;  ok_q <= 1'b0;
      done_q <= 1'b0;  error_q <= 1'b0;  cnt_q <= '0;  sum_q <= '0;  strb_q <= '0;
      addr_q <= '0;  len_q <= '0;  ptr_q <= '0;  buf_q <= '0;  waddr_q <= '0;  boot_q <= '0;
    end else begin
      state_q <= state_d;  wait_q <= wait_d;  flush_q <= flush_d;  ok_q <= ok_d;
      done_q <= done_d;  error_q <= error_d;  cnt_q <= cnt_d;  sum_q <= sum_d;
      strb_q <= strb_d;  addr_q <= addr_d;  len_q <= len_d;  ptr_q <= ptr_d;
      buf_q <= buf_d;  waddr_q <= waddr_d;  boot_q <= boot_d;
    end
  end

  assign mem_addr  = waddr_q;
  assign mem_wdata = buf_q;
  assign mem_wstrb = strb_q;
  assign mem_valid = flush_q;
  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = done_q;
  assign error     = error_q;
  assign boot_addr = boot_q;

endmodule
